// File: rtl/timer_seq.sv
// Multi-slot timer sequencer: steps one shared down-counter through a table of
// programmable periods, pulsing tick at the end of every slot.
module timer_seq #(
    parameter int unsigned NSLOT = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    input  logic [AW-1:0] last_slot,
    input  logic          repeat_en,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          tick,
    output logic [AW-1:0] slot_idx,
    output logic          done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  slot_tab_q [NSLOT];
    logic [W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0] slot_q, slot_d;
    logic [AW-1:0] next_slot;
    logic [AW-1:0] last_q, last_d;
    logic          rep_q, rep_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    // Counter is loaded with eff(P)-1, so zero and one both give a one-cycle slot
    // and the all-ones period needs no extra bit.
    function automatic logic [W-1:0] load_val(input logic [W-1:0] p);
        return (p == '0) ? '0 : p - W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_tab_q[i] <= '0;
            end
        end else if (cfg_we) begin
            slot_tab_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            slot_q  <= '0;
            last_q  <= '0;
            rep_q   <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
            rep_q   <= rep_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign next_slot = slot_q + AW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        last_d  = last_q;
        rep_d   = rep_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    last_d  = last_slot;
                    rep_d   = repeat_en;
                    slot_d  = '0;
                    cnt_d   = load_val(slot_tab_q[0]);
                end
            end
            StRun: begin
                // stop wins over a coincident slot end: no tick, no done.
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - W'(1);
                end else begin
                    tick_d = 1'b1;
                    if (slot_q != last_q) begin
                        slot_d = next_slot;
                        cnt_d  = load_val(slot_tab_q[next_slot]);
                    end else if (rep_q) begin
                        slot_d = '0;
                        cnt_d  = load_val(slot_tab_q[0]);
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q == StRun);
    assign tick     = tick_q;
    assign done     = done_q;
    assign slot_idx = slot_q;

endmodule

// File: tb/tb_timer_seq.sv
// Directed and randomized bench for timer_seq, checked against a model that
// schedules slot ends as absolute edge numbers.
module tb_timer_seq;

    localparam int unsigned NSLOT = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned W     = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cfg_we    = 1'b0;
    logic [AW-1:0] cfg_addr  = '0;
    logic [W-1:0]  cfg_data  = '0;
    logic [AW-1:0] last_slot = '0;
    logic          repeat_en = 1'b0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic          busy;
    logic          tick;
    logic [AW-1:0] slot_idx;
    logic          done;

    always #5 clk = ~clk;

    timer_seq #(
        .NSLOT(NSLOT),
        .AW   (AW),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .last_slot(last_slot),
        .repeat_en(repeat_en),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .tick     (tick),
        .slot_idx (slot_idx),
        .done     (done)
    );

    int unsigned     vectors     = 0;
    int unsigned     miscompares = 0;
    longint unsigned edge_n      = 0;

    // Reference model: table contents plus the absolute edge at which the
    // current slot ends.
    longint unsigned m_tab [NSLOT];
    longint unsigned m_end;
    bit              m_busy, m_tick, m_done, m_rep;
    int              m_slot, m_last;

    function automatic longint unsigned eff(input longint unsigned p);
        return (p == 0) ? 64'd1 : p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) m_tab[i] = 0;
        m_busy = 0; m_tick = 0; m_done = 0; m_rep = 0;
        m_slot = 0; m_last = 0; m_end = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        m_done = 0;
        if (m_busy) begin
            if (stop) begin
                m_busy = 0;
            end else if (edge_n == m_end) begin
                m_tick = 1;
                if (m_slot != m_last) begin
                    m_slot = m_slot + 1;
                    m_end  = edge_n + eff(m_tab[m_slot]);
                end else if (m_rep) begin
                    m_slot = 0;
                    m_end  = edge_n + eff(m_tab[0]);
                end else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (start && !stop) begin
            m_busy = 1;
            m_last = int'(last_slot);
            m_rep  = repeat_en;
            m_slot = 0;
            m_end  = edge_n + eff(m_tab[0]);
        end
        if (cfg_we) m_tab[cfg_addr] = 64'(cfg_data);
    endtask

    task automatic check_all();
        check("busy", 64'(busy), 64'(m_busy));
        check("tick", 64'(tick), 64'(m_tick));
        check("done", 64'(done), 64'(m_done));
        check("slot_idx", 64'(slot_idx), 64'(m_slot));
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_cfg(input int a, input longint unsigned d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = W'(d);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic kick(input int last, input bit rep);
        last_slot = AW'(last);
        repeat_en = rep;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    int n_ticks, n_done;

    initial begin
        model_reset();
        #3;
        check_all();
        #9;
        rst_n = 1'b1;
        run(2);

        // Single pass over {3,5,2,4}: ticks at E+3, E+8, E+10, E+14.
        write_cfg(0, 3);
        write_cfg(1, 5);
        write_cfg(2, 2);
        write_cfg(3, 4);
        kick(3, 1'b0);
        n_ticks = 0;
        n_done  = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (tick === 1'b1) n_ticks++;
            if (done === 1'b1) n_done++;
        end
        check("pass_ticks", 64'(n_ticks), 64'd4);
        check("pass_done", 64'(n_done), 64'd1);

        // Repeating two-slot sequence, then abort.
        kick(1, 1'b1);
        run(24);
        halt();

        // Zero and one periods repeating: tick high every cycle.
        write_cfg(0, 0);
        write_cfg(1, 1);
        kick(1, 1'b1);
        run(6);
        check("tick_solid", 64'(tick), 64'd1);
        halt();

        // stop on the edge where the counter hits zero.
        write_cfg(0, 3);
        write_cfg(1, 5);
        kick(3, 1'b0);
        run(2);
        halt();
        check("stop_no_tick", 64'(tick), 64'd0);
        kick(3, 1'b0);
        run(3);

        // Mid-run write to slot 2 and an ignored start pulse.
        halt();
        write_cfg(2, 2);
        kick(3, 1'b0);
        cfg_we   = 1'b1;
        cfg_addr = AW'(2);
        cfg_data = W'(7);
        start    = 1'b1;
        step();
        cfg_we   = 1'b0;
        start    = 1'b0;
        run(22);

        // All-ones period must not wrap into an early tick.
        write_cfg(0, 64'hFFFF_FFFF);
        kick(0, 1'b0);
        run(12);
        halt();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = AW'($urandom_range(0, NSLOT - 1));
            cfg_data  = W'($urandom_range(0, 6));
            start     = ($urandom_range(0, 4) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            last_slot = AW'($urandom_range(0, NSLOT - 1));
            repeat_en = 1'($urandom_range(0, 1));
            step();
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        halt();

        // Asynchronous reset while tick is solidly high.
        write_cfg(0, 0);
        write_cfg(1, 1);
        kick(1, 1'b1);
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        edge_n++;
        #3;
        rst_n = 1'b1;
        kick(3, 1'b0);
        run(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
